// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles little-endian bytes into 32-bit words
// and writes them to consecutive word addresses while holding the core in reset.
module imem_loader #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              len_err
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, RECV, WRITE, FINISH} state_t;

  state_t            state, state_n;
  logic [ADDR_W:0]   len, len_n;
  logic [ADDR_W-1:0] word_idx, word_idx_n;
  logic [1:0]        byte_idx, byte_idx_n;
  logic [31:0]       word, word_n;
  logic              len_err_n;
  logic              hs;

  // byte_ready is only ever high in RECV, so this is the accepted-byte strobe
  assign hs = byte_valid & byte_ready;

  always_comb begin
    state_n    = state;
    len_n      = len;
    word_idx_n = word_idx;
    byte_idx_n = byte_idx;
    word_n     = word;
    len_err_n  = len_err;
    case (state)
      IDLE: begin
        if (load_start) begin
          len_n      = (load_len > DEPTH) ? DEPTH : load_len;
          len_err_n  = (load_len > DEPTH);
          word_idx_n = '0;
          byte_idx_n = '0;
          word_n     = '0;
          state_n    = (load_len == '0) ? FINISH : RECV;
        end
      end
      RECV: begin
        if (hs) begin
          word_n[8*byte_idx +: 8] = byte_data;
          byte_idx_n              = byte_idx + 2'd1;
          if (byte_idx == 2'd3) state_n = WRITE;
        end
      end
      WRITE: begin
        if ({1'b0, word_idx} == len - (ADDR_W+1)'(1)) begin
          state_n = FINISH;
        end else begin
          word_idx_n = word_idx + ADDR_W'(1);
          state_n    = RECV;
        end
      end
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      len        <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      word       <= '0;
      len_err    <= 1'b0;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      len        <= len_n;
      word_idx   <= word_idx_n;
      byte_idx   <= byte_idx_n;
      word       <= word_n;
      len_err    <= len_err_n;
      byte_ready <= (state_n == RECV);
      imem_we    <= (state_n == WRITE);
      core_rst   <= (state_n != IDLE);
      busy       <= (state_n != IDLE);
      done       <= (state_n == FINISH);
      if (state_n == WRITE) begin
        imem_addr  <= word_idx;
        imem_wdata <= word_n;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: normal loads, stalled source,
// zero and oversize lengths, and reset in the middle of a session.
module tb_imem_loader;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              rst;
  logic              load_start;
  logic [ADDR_W:0]   load_len;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst;
  logic              busy;
  logic              done;
  logic              len_err;

  int checks = 0;
  int failures = 0;

  logic [ADDR_W-1:0] log_addr[$];
  logic [31:0]       log_data[$];
  int                done_cnt = 0;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst(core_rst), .busy(busy), .done(done), .len_err(len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write and done monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (imem_we) begin
      log_addr.push_back(imem_addr);
      log_data.push_back(imem_wdata);
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit hs;
    int n;
    if (gap) begin
      byte_valid = 1'b0;
      step();
    end
    byte_valid = 1'b1;
    byte_data  = b;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 20) begin
      hs = byte_ready;
      step();
      n++;
    end
    check_output("byte_accepted", 32'(hs), 32'd1);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 50) begin
      step();
      n++;
    end
    check_output(tag, 32'(done), 32'd1);
  endtask

  task automatic start_load(input logic [ADDR_W:0] n);
    load_start = 1'b1;
    load_len   = n;
    step();
    load_start = 1'b0;
  endtask

  initial begin
    int base;
    int dbase;
    int bad;
    logic [31:0] w;

    rst = 1'b1; load_start = 1'b0; load_len = '0; byte_valid = 1'b0; byte_data = '0;

    // Reset and idle
    step();
    check_output("rst_core_rst", 32'(core_rst), 32'd1);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_byte_ready", 32'(byte_ready), 32'd0);
    check_output("rst_imem_we", 32'(imem_we), 32'd0);
    check_output("rst_len_err", 32'(len_err), 32'd0);
    rst = 1'b0;
    check_output("release_core_rst_hold", 32'(core_rst), 32'd1);
    step();
    check_output("idle_core_rst", 32'(core_rst), 32'd0);
    step();
    check_output("idle_no_writes", 32'(log_data.size()), 32'd0);

    // Two-word load with continuous valid
    base = log_data.size(); dbase = done_cnt;
    start_load(2);
    check_output("s2_byte_ready", 32'(byte_ready), 32'd1);
    check_output("s2_core_rst", 32'(core_rst), 32'd1);
    check_output("s2_busy", 32'(busy), 32'd1);
    send_word(32'h00100513, 1'b0);
    check_output("s2_we0", 32'(imem_we), 32'd1);
    check_output("s2_addr0", 32'(imem_addr), 32'd0);
    check_output("s2_data0", imem_wdata, 32'h00100513);
    check_output("s2_ready_drop", 32'(byte_ready), 32'd0);
    send_word(32'h00700393, 1'b0);
    check_output("s2_we1", 32'(imem_we), 32'd1);
    check_output("s2_addr1", 32'(imem_addr), 32'd1);
    check_output("s2_data1", imem_wdata, 32'h00700393);
    step();
    check_output("s2_done", 32'(done), 32'd1);
    check_output("s2_finish_core_rst", 32'(core_rst), 32'd1);
    check_output("s2_finish_we", 32'(imem_we), 32'd0);
    step();
    check_output("s2_done_pulse", 32'(done), 32'd0);
    check_output("s2_core_rst_release", 32'(core_rst), 32'd0);
    check_output("s2_busy_idle", 32'(busy), 32'd0);
    check_output("s2_addr_hold", 32'(imem_addr), 32'd1);
    check_output("s2_write_count", 32'(log_data.size() - base), 32'd2);
    check_output("s2_done_count", 32'(done_cnt - dbase), 32'd1);

    // Same load with byte_valid toggling, plus an ignored mid-session load_start
    base = log_data.size(); dbase = done_cnt;
    start_load(2);
    load_start = 1'b1; load_len = 7'd5;
    step();
    load_start = 1'b0;
    send_byte(8'h13, 1'b1);
    byte_valid = 1'b0;
    step();
    check_output("s3_ready_in_stall", 32'(byte_ready), 32'd1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b1);
    send_word(32'h00700393, 1'b1);
    wait_done("s3_done");
    step();
    check_output("s3_write_count", 32'(log_data.size() - base), 32'd2);
    if (log_data.size() - base == 2) begin
      check_output("s3_addr0", 32'(log_addr[base]), 32'd0);
      check_output("s3_data0", log_data[base], 32'h00100513);
      check_output("s3_addr1", 32'(log_addr[base+1]), 32'd1);
      check_output("s3_data1", log_data[base+1], 32'h00700393);
    end
    check_output("s3_done_count", 32'(done_cnt - dbase), 32'd1);

    // Oversize length clamps to DEPTH
    base = log_data.size();
    start_load(7'd40);
    check_output("s5_len_err", 32'(len_err), 32'd1);
    for (int k = 0; k < 32; k++) begin
      w = {8'h11, 8'hC3, 8'(k) ^ 8'h5A, 8'(k)};
      send_word(w, 1'b0);
    end
    wait_done("s5_done");
    step();
    check_output("s5_write_count", 32'(log_data.size() - base), 32'd32);
    bad = 0;
    if (log_data.size() - base == 32) begin
      for (int k = 0; k < 32; k++) begin
        w = {8'h11, 8'hC3, 8'(k) ^ 8'h5A, 8'(k)};
        if (log_addr[base+k] !== 5'(k) || log_data[base+k] !== w) bad++;
      end
    end else bad = -1;
    check_output("s5_bad_words", 32'(bad), 32'd0);
    check_output("s5_len_err_sticky", 32'(len_err), 32'd1);
    check_output("s5_busy_idle", 32'(busy), 32'd0);

    // Zero length: done only, len_err cleared
    base = log_data.size(); dbase = done_cnt;
    start_load(0);
    check_output("s4_done", 32'(done), 32'd1);
    check_output("s4_core_rst", 32'(core_rst), 32'd1);
    check_output("s4_len_err", 32'(len_err), 32'd0);
    check_output("s4_we", 32'(imem_we), 32'd0);
    step();
    check_output("s4_done_pulse", 32'(done), 32'd0);
    check_output("s4_core_rst_release", 32'(core_rst), 32'd0);
    check_output("s4_no_writes", 32'(log_data.size() - base), 32'd0);
    check_output("s4_done_count", 32'(done_cnt - dbase), 32'd1);

    // Reset after 6 bytes of a 2-word load
    base = log_data.size();
    start_load(2);
    send_word(32'hCAFE0513, 1'b0);
    send_byte(8'h93, 1'b0);
    send_byte(8'h03, 1'b0);
    #1 rst = 1'b1;
    #1;
    check_output("s6_async_core_rst", 32'(core_rst), 32'd1);
    check_output("s6_async_busy", 32'(busy), 32'd0);
    check_output("s6_async_ready", 32'(byte_ready), 32'd0);
    check_output("s6_async_addr", 32'(imem_addr), 32'd0);
    check_output("s6_async_wdata", imem_wdata, 32'd0);
    step();
    rst = 1'b0;
    step();
    check_output("s6_core_rst_release", 32'(core_rst), 32'd0);
    check_output("s6_write_count", 32'(log_data.size() - base), 32'd1);
    if (log_data.size() - base == 1) begin
      check_output("s6_addr0", 32'(log_addr[base]), 32'd0);
      check_output("s6_data0", log_data[base], 32'hCAFE0513);
    end
    base = log_data.size();
    start_load(1);
    send_word(32'h00001237, 1'b0);
    check_output("s6_new_we", 32'(imem_we), 32'd1);
    check_output("s6_new_addr", 32'(imem_addr), 32'd0);
    check_output("s6_new_data", imem_wdata, 32'h00001237);
    step();
    check_output("s6_new_done", 32'(done), 32'd1);
    step();
    check_output("s6_new_busy", 32'(busy), 32'd0);
    check_output("s6_new_write_count", 32'(log_data.size() - base), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side counterpart to the datapath's instruction fetch: streams a program into instruction memory over a byte handshake before the core runs.
- Assembles little-endian bytes into 32-bit words and writes them to consecutive instruction-memory word addresses starting at 0.
- Holds the core in reset (core_rst) for the whole load session and releases it after the last write.
- Sits between the simulation or host byte source and the instruction memory write port, alongside main.

Parameters:
ADDR_W, 5, instruction-memory word-address width; DEPTH = 2**ADDR_W words (default 32).

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
load_start  input  1  one-cycle request to begin a load session; sampled only in IDLE.
load_len  input  ADDR_W+1  number of 32-bit words to load; sampled together with load_start.
byte_valid  input  1  source has a byte on byte_data.
byte_data  input  8  program byte, little-endian within each word.
byte_ready  output  1  loader accepts a byte this cycle; a handshake is byte_valid & byte_ready.
imem_we  output  1  instruction-memory write strobe, one cycle per word.
imem_addr  output  ADDR_W  word address of the current write.
imem_wdata  output  32  assembled word.
core_rst  output  1  reset for the datapath; high while loading.
busy  output  1  high in any state other than IDLE.
done  output  1  one-cycle pulse when a session completes.
len_err  output  1  sticky: load_len exceeded DEPTH; cleared by the next accepted load_start.

Behaviour:
- Reset (async, rst=1) forces the following, with all counters and the word register cleared:
  - state=IDLE
  - byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0
  - core_rst=1, busy=0, done=0, len_err=0
- After rst falls, the first clock in IDLE drives core_rst=0.
- All outputs are registered.
- FSM states:
  - IDLE: byte_ready=0, core_rst=0. On load_start:
    - latch len = min(load_len, DEPTH).
    - set len_err = (load_len > DEPTH).
    - clear word_idx and byte_idx.
    - next state = FINISH if len=0, else RECV.
  - RECV: byte_ready=1, core_rst=1.
    - Each handshake stores byte_data into wdata[8*byte_idx +: 8] and increments byte_idx (2-bit).
    - The handshake with byte_idx=3 moves to WRITE; byte_ready drops the next cycle.
    - byte_valid low stalls indefinitely with no timeout.
  - WRITE: exactly one cycle; byte_ready=0, core_rst=1.
    - imem_we=1, imem_addr=word_idx, imem_wdata=assembled word.
    - If word_idx = len-1, next state = FINISH.
    - Otherwise increment word_idx and return to RECV.
  - FINISH: one cycle; done=1, core_rst=1, then IDLE (core_rst=0 from the following cycle).
- Latency:
  - imem_we asserts on the cycle immediately after the 4th byte handshake of a word.
  - Minimum 5 cycles per word.
  - done follows the last imem_we by one cycle.
- load_start is ignored outside IDLE; a session cannot be restarted mid-load.
- load_len=0 gives a done pulse with no writes and core_rst high for exactly the FINISH cycle.
- load_len=DEPTH fills addresses 0..DEPTH-1; word_idx never wraps.
- Bytes presented while byte_ready=0 are not consumed; the source must hold them.
- Reset mid-session:
  - The partial word is discarded; words already written remain in memory.
  - Outputs return to reset values immediately, not at the clock edge.
- imem_we is never high outside WRITE; imem_addr and imem_wdata hold their last values otherwise.

Test Plan:
- Reset then idle → core_rst=1 during rst; 0 one cycle after release; busy=0, byte_ready=0, no imem_we.
- load_start with load_len=2, bytes 13 05 10 00 then 93 03 70 00 with continuous valid → imem_we at addr 0 data 0x00100513, then addr 1 data 0x00700393; done pulses once; core_rst high from the cycle after start through FINISH.
- Same as the previous scenario but byte_valid toggles 1/0 each cycle → identical writes, only later; byte_ready stays 1 in RECV.
- load_len=0 → done pulse on the cycle after start, no imem_we, len_err=0.
- load_len=40 with ADDR_W=5 → len_err=1, exactly 32 writes to addresses 0..31, then done.
- rst pulsed after 6 bytes of a 2-word load → one write (addr 0) only, immediate return to reset values; a new load_start with load_len=1 then completes normally.
